// File: rtl/proc_pkg.sv
// Shared processor definitions: memory geometry, the program loader state
// encoding and the instruction field bit positions used by the decoder.
// No ports; imported with import proc_pkg::*.
package proc_pkg;

   localparam int DEPTH = 64;  // instruction memory entries
   localparam int AW    = 6;   // clog2(DEPTH)
   localparam int DW    = 32;  // instruction word width, 4 bytes

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } loader_state_t;

   // Instruction field positions; opaque to the loader.
   localparam int INSTR_TYPE_BIT = 0;
   localparam int RS_LSB         = 1;
   localparam int RS_MSB         = 6;
   localparam int RD_LSB         = 7;
   localparam int RD_MSB         = 12;
   localparam int FUNCT_LSB      = 13;
   localparam int FUNCT_MSB      = 16;
   localparam int R_RT_LSB       = 17;
   localparam int R_RT_MSB       = 22;
   localparam int R_IMM_LSB      = 23;
   localparam int R_IMM_MSB      = 31;
   localparam int I_IMM_LSB      = 17;
   localparam int I_IMM_MSB      = 31;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte word assembler.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clear           restart assembly at byte 0 (new load)
//   i_valid, i_byte   accepted stream byte
//   o_word            assembled word; the first byte of a word ends in [7:0]
//   o_word_ready      high on the cycle the 4th byte of a word is accepted
module byte_packer
   import proc_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clear,
   input  logic          i_valid,
   input  logic [7:0]    i_byte,
   output logic [DW-1:0] o_word,
   output logic          o_word_ready
);

   logic [1:0]    r_idx;
   logic [DW-1:0] r_word;

   // Shift right so that after four bytes the oldest one sits in [7:0].
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_idx  <= 2'd0;
         r_word <= '0;
      end else if (i_valid) begin
         r_idx  <= r_idx + 2'd1;
         r_word <= {i_byte, r_word[DW-1:8]};
      end
   end

   assign o_word       = r_word;
   assign o_word_ready = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader. Receives a frame (length N, 4*N little-endian
// data bytes, XOR checksum), writes each assembled word to the instruction
// memory at consecutive addresses and holds the CPU while loading.
// Ports:
//   clk, clkreset              clock, synchronous active-high reset
//   start                      begin a load (accepted in IDLE/DONE/ERROR)
//   byte_valid, byte_data      stream input; byte_ready gives back-pressure
//   imem_we/imem_addr/wdata    one-cycle write strobe with address and data
//   cpu_hold                   processor held in reset while high
//   done, err                  sticky load status
//   word_count                 words written in the current load
module imem_loader
   import proc_pkg::*;
(
   input  logic          clk,
   input  logic          clkreset,
   input  logic          start,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [DW-1:0] imem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err,
   output logic [AW:0]   word_count
);

   loader_state_t r_state, w_state_nxt;

   logic [AW:0]   r_n;
   logic [AW:0]   r_word_count;
   logic [AW:0]   w_wc_inc;
   logic [7:0]    r_checksum;
   logic          r_cpu_hold;
   logic          r_done;
   logic          r_err;
   logic          w_xfer;
   logic          w_start_ok;
   logic          w_len_ok;
   logic          w_data_xfer;
   logic          w_word_ready;
   logic [DW-1:0] w_word;

   assign w_xfer      = byte_valid && byte_ready;
   assign w_start_ok  = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign w_len_ok    = (byte_data != 8'd0) && (byte_data <= 8'(DEPTH));
   assign w_data_xfer = w_xfer && (r_state == ST_DATA);
   assign w_wc_inc    = r_word_count + (AW+1)'(1);

   byte_packer u_packer (
      .i_clk        (clk),
      .i_rst        (clkreset),
      .i_clear      (w_start_ok),
      .i_valid      (w_data_xfer),
      .i_byte       (byte_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
   );

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (clkreset) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ---- next-state logic ----
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: if (start) w_state_nxt = ST_LEN;
         ST_LEN:   if (w_xfer) w_state_nxt = w_len_ok ? ST_DATA : ST_ERROR;
         ST_DATA:  if (w_word_ready) w_state_nxt = ST_WRITE;
         ST_WRITE: w_state_nxt = (w_wc_inc == r_n) ? ST_CHECK : ST_DATA;
         ST_CHECK: if (w_xfer) w_state_nxt = (byte_data == r_checksum) ? ST_DONE : ST_ERROR;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // ---- outputs ----
   always_comb begin
      byte_ready = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHECK);
      imem_we    = (r_state == ST_WRITE);
   end

   assign imem_addr  = r_word_count[AW-1:0];
   assign imem_wdata = w_word;
   assign cpu_hold   = r_cpu_hold;
   assign done       = r_done;
   assign err        = r_err;
   assign word_count = r_word_count;

   // ---- loader control registers ----
   always_ff @(posedge clk) begin
      if (clkreset) begin
         r_cpu_hold   <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_word_count <= '0;
         r_checksum   <= 8'd0;
      end else begin
         // Release the CPU one cycle after DONE; a restart below overrides.
         if (r_state == ST_DONE) r_cpu_hold <= 1'b0;
         if (w_data_xfer) r_checksum <= r_checksum ^ byte_data;
         if (r_state == ST_WRITE) r_word_count <= w_wc_inc;
         if ((r_state == ST_LEN) && w_xfer && !w_len_ok) r_err <= 1'b1;
         if ((r_state == ST_CHECK) && w_xfer) begin
            if (byte_data == r_checksum) r_done <= 1'b1;
            else                         r_err  <= 1'b1;
         end
         if (w_start_ok) begin
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_checksum   <= 8'd0;
         end
      end
   end

   // Length is only meaningful once LEN has accepted a legal value.
   always_ff @(posedge clk) begin
      if ((r_state == ST_LEN) && w_xfer && w_len_ok) r_n <= byte_data[AW:0];
   end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
   import proc_pkg::*;

   logic          clk = 1'b0;
   logic          clkreset;
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;
   logic [AW:0]   word_count;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   logic [DW-1:0] ref_data[$];
   logic [DW-1:0] words_q[$];
   logic [7:0]    frame_q[$];

   imem_loader dut (
      .clk        (clk),
      .clkreset   (clkreset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Record every memory write seen by the bench.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         log_addr.push_back(imem_addr);
         log_data.push_back(imem_wdata);
      end
   end

   // Reference model: frame = N, little-endian bytes of each word, XOR of data bytes.
   task automatic build_frame(input bit corrupt);
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'd0;
      frame_q = {};
      frame_q.push_back(8'(words_q.size()));
      foreach (words_q[i]) begin
         for (int k = 0; k < 4; k++) begin
            b = words_q[i][8*k +: 8];
            frame_q.push_back(b);
            cs = cs ^ b;
         end
      end
      frame_q.push_back(corrupt ? (cs ^ 8'h01) : cs);
   endtask

   task automatic random_words(input int n);
      words_q = {};
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the byte was taken.
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (byte_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_timeout byte_ready=%b required=1", byte_ready);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic run_frame(input int gap_pct, input int poke_idx);
      log_addr = {};
      log_data = {};
      pulse_start();
      for (int i = 0; i < frame_q.size(); i++) begin
         if (i == poke_idx) pulse_start();
         if (int'($urandom_range(99)) < gap_pct) repeat ($urandom_range(3, 1)) @(negedge clk);
         send_byte(frame_q[i]);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      clkreset = 1'b1;
      start    = 1'b1;   // same cycle as reset: reset must win
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({byte_ready, imem_we, cpu_hold, done, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl ready/we/hold/done/err=%b required=00000",
                  {byte_ready, imem_we, cpu_hold, done, err});
      end
      checks++;
      if ({imem_addr, imem_wdata, word_count} !== '0) begin
         errors++;
         $display("FAIL reset_data addr=%0d wdata=%h count=%0d required=0", imem_addr, imem_wdata, word_count);
      end
      start    = 1'b0;
      clkreset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] fr [6];
      fr = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      log_addr = {};
      log_data = {};
      pulse_start();
      checks++;
      if (cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL basic_hold_loading cpu_hold=%b required=1", cpu_hold);
      end
      for (int i = 0; i < 5; i++) send_byte(fr[i]);
      checks++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 6'd0, 32'h12345678}) begin
         errors++;
         $display("FAIL basic_write we=%b addr=%0d data=%h required we=1 addr=0 data=12345678",
                  imem_we, imem_addr, imem_wdata);
      end
      send_byte(fr[5]);
      checks++;
      if ({done, err, cpu_hold} !== 3'b101) begin
         errors++;
         $display("FAIL basic_done done/err/hold=%b required=101", {done, err, cpu_hold});
      end
      @(negedge clk);
      checks++;
      if (cpu_hold !== 1'b0 || word_count !== 7'd1 || log_addr.size() != 1) begin
         errors++;
         $display("FAIL basic_release hold=%b count=%0d writes=%0d required hold=0 count=1 writes=1",
                  cpu_hold, word_count, log_addr.size());
      end
   endtask

   task automatic test_full();
      int bad;
      random_words(DEPTH);
      build_frame(1'b0);
      run_frame(0, -1);
      checks++;
      if (log_addr.size() != DEPTH) begin
         errors++;
         $display("FAIL full_nwrites got=%0d required=%0d", log_addr.size(), DEPTH);
      end
      bad = 0;
      for (int i = 0; i < log_addr.size() && i < DEPTH; i++) begin
         checks++;
         if (log_addr[i] !== 6'(i) || log_data[i] !== words_q[i]) begin
            errors++;
            bad++;
            if (bad < 4)
               $display("FAIL full_write[%0d] addr=%0d data=%h required addr=%0d data=%h",
                        i, log_addr[i], log_data[i], i, words_q[i]);
         end
      end
      checks++;
      if (word_count !== 7'd64 || done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL full_status count=%0d done=%b err=%b hold=%b required 64 1 0 0",
                  word_count, done, err, cpu_hold);
      end
   endtask

   task automatic test_bad_checksum();
      words_q = '{32'h12345678};
      build_frame(1'b1);
      run_frame(0, -1);
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 1 || log_data[0] !== 32'h12345678) begin
         errors++;
         $display("FAIL badcs_write writes=%0d required=1 data 12345678", log_addr.size());
      end
      checks++;
      if ({done, err, cpu_hold} !== 3'b011) begin
         errors++;
         $display("FAIL badcs_status done/err/hold=%b required=011", {done, err, cpu_hold});
      end
   endtask

   task automatic test_bad_len();
      logic [7:0] lens [2];
      lens = '{8'h00, 8'h41};
      foreach (lens[j]) begin
         log_addr = {};
         log_data = {};
         pulse_start();
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL badlen_clear[%0d] err=%b required=0", j, err);
         end
         send_byte(lens[j]);
         repeat (2) @(negedge clk);
         checks++;
         if ({err, done, cpu_hold, byte_ready} !== 4'b1010 || log_addr.size() != 0) begin
            errors++;
            $display("FAIL badlen[%0d] err/done/hold/ready=%b writes=%0d required=1010 writes=0",
                     j, {err, done, cpu_hold, byte_ready}, log_addr.size());
         end
      end
      random_words(3);
      build_frame(1'b0);
      run_frame(0, -1);
      checks++;
      if ({done, err, cpu_hold} !== 3'b100 || log_addr.size() != 3 || log_data[2] !== words_q[2]) begin
         errors++;
         $display("FAIL badlen_recover done/err/hold=%b writes=%0d required=100 writes=3",
                  {done, err, cpu_hold}, log_addr.size());
      end
   endtask

   task automatic test_gaps_start();
      int n;
      n = $urandom_range(20, 2);
      random_words(n);
      build_frame(1'b0);
      run_frame(0, -1);
      ref_data = log_data;
      run_frame(50, 7);
      checks++;
      if (log_data.size() != n || ref_data.size() != n) begin
         errors++;
         $display("FAIL gaps_nwrites got=%0d ref=%0d required=%0d", log_data.size(), ref_data.size(), n);
      end
      for (int i = 0; i < n && i < log_data.size() && i < ref_data.size(); i++) begin
         checks++;
         if (log_addr[i] !== 6'(i) || log_data[i] !== words_q[i] || ref_data[i] !== words_q[i]) begin
            errors++;
            $display("FAIL gaps_write[%0d] addr=%0d data=%h ref=%h required addr=%0d data=%h",
                     i, log_addr[i], log_data[i], ref_data[i], i, words_q[i]);
         end
      end
      checks++;
      if ({done, err} !== 2'b10 || word_count !== 7'(n)) begin
         errors++;
         $display("FAIL gaps_status done/err=%b count=%0d required=10 count=%0d", {done, err}, word_count, n);
      end
   endtask

   task automatic test_reset_midload();
      random_words(4);
      build_frame(1'b0);
      log_addr = {};
      log_data = {};
      pulse_start();
      for (int i = 0; i < 9; i++) send_byte(frame_q[i]);
      clkreset = 1'b1;
      @(negedge clk);
      checks++;
      if ({byte_ready, imem_we, cpu_hold, done, err} !== 5'b0 || {imem_addr, imem_wdata, word_count} !== '0) begin
         errors++;
         $display("FAIL midreset ready/we/hold/done/err=%b addr=%0d wdata=%h count=%0d required all 0",
                  {byte_ready, imem_we, cpu_hold, done, err}, imem_addr, imem_wdata, word_count);
      end
      clkreset = 1'b0;
      @(negedge clk);
      checks++;
      if (log_addr.size() != 2) begin
         errors++;
         $display("FAIL midreset_writes got=%0d required=2", log_addr.size());
      end
      random_words(3);
      build_frame(1'b0);
      run_frame(0, -1);
      checks++;
      if ({done, err, cpu_hold} !== 3'b100 || log_addr.size() != 3 || log_data[0] !== words_q[0]) begin
         errors++;
         $display("FAIL midreset_fresh done/err/hold=%b writes=%0d required=100 writes=3",
                  {done, err, cpu_hold}, log_addr.size());
      end
   endtask

   initial begin
      clkreset   = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_full();
      test_bad_checksum();
      test_bad_len();
      test_gaps_start();
      test_reset_midload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
